press_decoder: RTL
==================

PRESS_DECODER -- requirements
Module: press_decoder

Interface
REQ-001 Parameter LONG_CYCLES, default 50_000_000, hold duration in clk cycles that qualifies a long press; legal range 2..2^26-1.
REQ-002 Parameter REPEAT_CYCLES, default 10_000_000, auto-repeat period in clk cycles after a long press; legal range 2..2^26-1.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clean  input  1  debounced button level (1 = pressed), synchronous to clk, from the upstream debouncer.
REQ-006 press  output  1  one-cycle pulse on each press.
REQ-007 release_p  output  1  one-cycle pulse on each release.
REQ-008 long_press  output  1  one-cycle pulse when a hold reaches LONG_CYCLES.
REQ-009 rpt  output  1  one-cycle pulse every REPEAT_CYCLES while held past a long press.
REQ-010 held  output  1  level, high while the decoder is in PRESSED or LONG.

Function
REQ-011 All outputs registered; no combinational path from clean to any output.
REQ-012 Internal prev register holds clean from the previous edge; press edge = clean 1 and prev 0; release edge = clean 0 and prev 1.
REQ-013 FSM states IDLE, PRESSED, LONG; encoding at implementer's choice.
REQ-014 IDLE: on press edge -> PRESSED, hold_cnt cleared to 0, press = 1 for the following cycle.
REQ-015 PRESSED: at each edge with clean 1, if hold_cnt == LONG_CYCLES-1 -> LONG, long_press = 1 for one cycle, rpt_cnt cleared to 0; else hold_cnt increments.
REQ-016 LONG: at each edge with clean 1, if rpt_cnt == REPEAT_CYCLES-1 -> rpt = 1 for one cycle and rpt_cnt = 0; else rpt_cnt increments.
REQ-017 PRESSED or LONG: at an edge with clean 0 -> IDLE, release_p = 1 for one cycle, both counters cleared.
REQ-018 Timing: long_press asserts exactly LONG_CYCLES cycles after press asserts; first rpt exactly REPEAT_CYCLES cycles after long_press; subsequent rpt every REPEAT_CYCLES cycles.
REQ-019 Release on the edge where hold_cnt == LONG_CYCLES-1 or rpt_cnt == REPEAT_CYCLES-1: release wins; no long_press or rpt pulse that edge.
REQ-020 press and release_p never assert in the same cycle; at most one of press, release_p, long_press, rpt is high in any cycle.
REQ-021 Counters 26 bits unsigned; they never wrap, as they are cleared at terminal count or release.
REQ-022 Releasing after LONG_CYCLES does not produce a second press; a new press requires a release edge first.
REQ-023 held = 1 in cycles following entry to PRESSED until the cycle following the release edge; then 0.

Reset
REQ-024 rst_n low: state IDLE, prev 0, hold_cnt 0, rpt_cnt 0, all outputs 0, effective immediately without clk.
REQ-025 Reset asserted mid-hold aborts with no pulses; after rst_n rises with clean already 1, the first edge is treated as a press edge (prev reset to 0).
REQ-026 No pulse output asserts during or in the first cycle coinciding with reset release other than per REQ-025.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4 unless stated)
REQ-027 Short press: clean high 3 cycles then low -> press 1 cycle, held 3 cycles, release_p 1 cycle, no long_press/rpt.
REQ-028 Long hold: clean high 20 cycles -> press at cycle 1, long_press at cycle 9, rpt at cycles 13, 17, 21; release_p after clean falls.
REQ-029 Boundary release: clean high exactly 8 cycles -> release on terminal edge, long_press never asserts, release_p asserts.
REQ-030 Async reset: rst_n low at cycle 5 of a long hold, no clk edge -> all outputs 0 immediately; rst_n high with clean 1 -> press next edge.
REQ-031 Back-to-back: clean 1,0,1,0 per cycle -> press, release_p, press, release_p on consecutive cycles, never two pulses in one cycle.
REQ-032 Parameter sweep LONG_CYCLES=2, REPEAT_CYCLES=2: long_press 2 cycles after press, rpt every 2 cycles thereafter.

Source files
------------

// File: rtl/press_decoder.sv
// Button press decoder: turns a debounced level into press, release,
// long-press and auto-repeat pulses, plus a registered held level.
module press_decoder #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean,
  output logic press,
  output logic release_p,
  output logic long_press,
  output logic rpt,
  output logic held
);

  // state     | meaning
  // S_IDLE    | button up, waiting for a rising edge of clean
  // S_PRESSED | button down, counting towards a long press
  // S_LONG    | long press reached, emitting periodic repeats
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } state_t;

  localparam logic [25:0] HOLD_TC = 26'(LONG_CYCLES - 1);
  localparam logic [25:0] RPT_TC  = 26'(REPEAT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_prev;
  logic [25:0] r_hold_cnt;
  logic [25:0] r_rpt_cnt;
  logic [25:0] w_hold_nxt;
  logic [25:0] w_rpt_cnt_nxt;
  logic        w_press_nxt;
  logic        w_release_nxt;
  logic        w_long_nxt;
  logic        w_rpt_nxt;
  logic        w_rise;

  assign w_rise = clean & ~r_prev;

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_rpt_cnt_nxt = r_rpt_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    w_rpt_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_PRESSED;
          w_hold_nxt  = '0;
          w_press_nxt = 1'b1;
        end
      end
      S_PRESSED: begin
        // Release is checked first so it wins over the terminal count.
        if (!clean) begin
          w_state_nxt   = S_IDLE;
          w_hold_nxt    = '0;
          w_rpt_cnt_nxt = '0;
          w_release_nxt = 1'b1;
        end else if (r_hold_cnt == HOLD_TC) begin
          w_state_nxt   = S_LONG;
          w_rpt_cnt_nxt = '0;
          w_long_nxt    = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + 26'd1;
        end
      end
      S_LONG: begin
        if (!clean) begin
          w_state_nxt   = S_IDLE;
          w_hold_nxt    = '0;
          w_rpt_cnt_nxt = '0;
          w_release_nxt = 1'b1;
        end else if (r_rpt_cnt == RPT_TC) begin
          w_rpt_cnt_nxt = '0;
          w_rpt_nxt     = 1'b1;
        end else begin
          w_rpt_cnt_nxt = r_rpt_cnt + 26'd1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_hold_nxt    = '0;
        w_rpt_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_prev     <= 1'b0;
      r_hold_cnt <= '0;
      r_rpt_cnt  <= '0;
      press      <= 1'b0;
      release_p  <= 1'b0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
      held       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= clean;
      r_hold_cnt <= w_hold_nxt;
      r_rpt_cnt  <= w_rpt_cnt_nxt;
      press      <= w_press_nxt;
      release_p  <= w_release_nxt;
      long_press <= w_long_nxt;
      rpt        <= w_rpt_nxt;
      held       <= (w_state_nxt != S_IDLE);
    end
  end

endmodule
